// File: rtl/mux_sel_pkg.sv
// Shared select encodings and debounce default for the U/V/W channel-select sequencer.
package mux_sel_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  // Encoding equals the multiplexer S value; 2'd3 is never produced.
  typedef enum logic [1:0] {
    SEL_U = 2'd0,
    SEL_V = 2'd1,
    SEL_W = 2'd2
  } sel_t;

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Pushbutton inputs and select outputs of the channel-select sequencer.
interface mux_select_sequencer_if;
  import mux_sel_pkg::*;

  logic [1:0] KEY;
  sel_t       sel;
  logic       sel_changed;
  logic [1:0] LEDR;

  modport master (output KEY, input sel, input sel_changed, input LEDR);
  modport slave  (input KEY, output sel, output sel_changed, output LEDR);
endinterface

// File: rtl/key_debounce.sv
// One pushbutton path: 2-flop synchronizer, debounce counter and registered press strobe.
module key_debounce
  import mux_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          pressed_sync;
  logic [CW-1:0] cnt;
  logic          level_q;
  logic          level_d;
  logic          press_q;

  assign pressed_sync = ~sync2;

  // Counter restarts on every sample matching the accepted level, so bounces reset it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      level_q <= 1'b0;
      level_d <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      level_d <= level_q;
      press_q <= level_q & ~level_d;
      if (pressed_sync == level_q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt     <= '0;
        level_q <= pressed_sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/mux_select_sequencer.sv
// Pushbutton-driven U->V->W select for the 3-to-1 channel mux, mirrored on LEDR.
// Define SEL_REVERSE_EN to build the KEY[1] step-back path.
module mux_select_sequencer
  import mux_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  mux_select_sequencer_if.slave  bus
);

  logic fwd;
  logic back;
  logic level_fwd_unused;
  sel_t state_q;
  sel_t state_n;
  logic chg_nxt;
  logic chg_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fwd (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (bus.KEY[0]),
    .level    (level_fwd_unused),
    .press    (fwd)
  );

`ifdef SEL_REVERSE_EN
  logic level_back_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (bus.KEY[1]),
    .level    (level_back_unused),
    .press    (back)
  );
`else
  logic key1_unused;

  assign key1_unused = bus.KEY[1];
  assign back        = 1'b0;
`endif

  // State and registered change pulse; reset wins over any strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= SEL_U;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      chg_q   <= chg_nxt;
    end
  end

  // Simultaneous forward and back strobes cancel.
  always_comb begin
    state_n = state_q;
    if (fwd && !back) begin
      case (state_q)
        SEL_U:   state_n = SEL_V;
        SEL_V:   state_n = SEL_W;
        SEL_W:   state_n = SEL_U;
        default: state_n = SEL_U;
      endcase
    end else if (back && !fwd) begin
      case (state_q)
        SEL_U:   state_n = SEL_W;
        SEL_W:   state_n = SEL_V;
        SEL_V:   state_n = SEL_U;
        default: state_n = SEL_U;
      endcase
    end
  end

  always_comb begin
    chg_nxt = 1'b0;
    if (state_n != state_q) chg_nxt = 1'b1;
  end

  assign bus.sel         = state_q;
  assign bus.LEDR        = state_q;
  assign bus.sel_changed = chg_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Randomized and directed bench for mux_select_sequencer against a sample-domain reference model.
module tb_mux_select_sequencer;
  import mux_sel_pkg::*;

  localparam int unsigned DB = 4;
`ifdef SEL_REVERSE_EN
  localparam int NK = 2;
`else
  localparam int NK = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mux_select_sequencer_if bus ();

  mux_select_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Model: a key level is accepted after DB consecutive raw samples that disagree with it;
  // an accepted press moves sel 4 edges after its last counted sample.
  int   m_pos;
  logic m_chg;
  logic m_lvl[2];
  int   m_run[2];
  int   q_due[2][$];

  task automatic model_edge(input logic [1:0] k, input logic r);
    logic p, f, b;
    cyc_n++;
    if (r) begin
      m_pos = 0;
      m_chg = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_lvl[i] = 1'b0;
        m_run[i] = 0;
        q_due[i].delete();
      end
      return;
    end
    for (int i = 0; i < NK; i++) begin
      p = ~k[i];
      if (p != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == int'(DB)) begin
        m_lvl[i] = p;
        m_run[i] = 0;
        if (p) q_due[i].push_back(cyc_n + 4);
      end
    end
    f = 1'b0;
    b = 1'b0;
    if (q_due[0].size() > 0 && q_due[0][0] == cyc_n) begin f = 1'b1; void'(q_due[0].pop_front()); end
    if (q_due[1].size() > 0 && q_due[1][0] == cyc_n) begin b = 1'b1; void'(q_due[1].pop_front()); end
    m_chg = f ^ b;
    if (f && !b) m_pos = (m_pos + 1) % 3;
    if (b && !f) m_pos = (m_pos + 2) % 3;
  endtask

  task automatic cyc(input logic [1:0] k, input logic r);
    @(negedge clk);
    bus.KEY = k;
    reset   = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(2'b11, 1'b1);
    for (int i = 0; i < 50; i++) begin
      cyc(2'b11, 1'b0);
      n_cmp++;
      if (bus.sel !== 2'd0 || bus.LEDR !== 2'd0 || bus.sel_changed !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc %0d: sel=%0d ledr=%0d chg=%b, want 0/0/0",
                 cyc_n, bus.sel, bus.LEDR, bus.sel_changed);
      end
    end
  endtask

  task automatic test_single_press();
    int n, pulses, at;
    pulses = 0;
    at = -1;
    cyc(2'b11, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cyc((i < 20) ? 2'b10 : 2'b11, 1'b0);
      if (i == 0) n = cyc_n;
      if (bus.sel_changed === 1'b1) begin pulses++; at = cyc_n; end
      n_cmp++;
      if (bus.sel !== 2'(m_pos) || bus.LEDR !== 2'(m_pos) || bus.sel_changed !== m_chg) begin
        n_bad++;
        $display("FAIL single_press cyc %0d: sel=%0d ledr=%0d chg=%b, want sel=%0d chg=%b",
                 cyc_n, bus.sel, bus.LEDR, bus.sel_changed, m_pos, m_chg);
      end
    end
    n_cmp++;
    if (pulses != 1 || at != n + 7 || bus.sel !== 2'd1) begin
      n_bad++;
      $display("FAIL single_latency: pulses=%0d at=%0d sel=%0d, want 1 pulse at %0d sel=1",
               pulses, at - n, bus.sel, 7);
    end
  endtask

  task automatic test_three_presses();
    int pulses;
    logic [1:0] seen[3];
    pulses = 0;
    cyc(2'b11, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        cyc((i < 10) ? 2'b10 : 2'b11, 1'b0);
        if (bus.sel_changed === 1'b1) begin
          if (pulses < 3) seen[pulses] = bus.sel;
          pulses++;
        end
        n_cmp++;
        if (bus.sel === 2'd3 || bus.sel !== 2'(m_pos) || bus.sel_changed !== m_chg) begin
          n_bad++;
          $display("FAIL three_press cyc %0d: sel=%0d chg=%b, want sel=%0d chg=%b",
                   cyc_n, bus.sel, bus.sel_changed, m_pos, m_chg);
        end
      end
    end
    n_cmp++;
    if (pulses != 3 || seen[0] !== 2'd1 || seen[1] !== 2'd2 || seen[2] !== 2'd0) begin
      n_bad++;
      $display("FAIL three_seq: pulses=%0d seq=%0d,%0d,%0d, want 3 pulses seq 1,2,0",
               pulses, seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_bounce();
    logic [1:0] pat[12];
    int f, pulses, at;
    pat = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11,
            2'b10, 2'b10, 2'b10};
    pulses = 0;
    at = -1;
    f = 0;
    cyc(2'b11, 1'b1);
    for (int i = 0; i < 30; i++) begin
      cyc((i < 12) ? pat[i] : 2'b10, 1'b0);
      if (i == 9) f = cyc_n;
      if (bus.sel_changed === 1'b1) begin pulses++; at = cyc_n; end
      n_cmp++;
      if (bus.sel !== 2'(m_pos) || bus.sel_changed !== m_chg) begin
        n_bad++;
        $display("FAIL bounce cyc %0d: sel=%0d chg=%b, want sel=%0d chg=%b",
                 cyc_n, bus.sel, bus.sel_changed, m_pos, m_chg);
      end
    end
    n_cmp++;
    if (pulses != 1 || at != f + 7) begin
      n_bad++;
      $display("FAIL bounce_latency: pulses=%0d at=+%0d, want 1 pulse at +7", pulses, at - f);
    end
  endtask

`ifdef SEL_REVERSE_EN
  task automatic test_reverse();
    int pulses;
    cyc(2'b11, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc((i < 10) ? 2'b01 : 2'b11, 1'b0);
      n_cmp++;
      if (bus.sel !== 2'(m_pos) || bus.sel_changed !== m_chg) begin
        n_bad++;
        $display("FAIL reverse cyc %0d: sel=%0d chg=%b, want sel=%0d chg=%b",
                 cyc_n, bus.sel, bus.sel_changed, m_pos, m_chg);
      end
    end
    n_cmp++;
    if (bus.sel !== 2'd2) begin
      n_bad++;
      $display("FAIL reverse_step: sel=%0d, want 2", bus.sel);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc((i < 10) ? 2'b00 : 2'b11, 1'b0);
      if (bus.sel_changed === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || bus.sel !== 2'd2) begin
      n_bad++;
      $display("FAIL both_cancel: pulses=%0d sel=%0d, want 0 pulses sel=2", pulses, bus.sel);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int r, pulses, at;
    pulses = 0;
    at = -1;
    cyc(2'b11, 1'b1);
    for (int i = 0; i < 4; i++) cyc(2'b10, 1'b0);
    cyc(2'b10, 1'b1);
    r = cyc_n;
    n_cmp++;
    if (bus.sel !== 2'd0 || bus.sel_changed !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_clear: sel=%0d chg=%b, want 0/0", bus.sel, bus.sel_changed);
    end
    for (int i = 0; i < 15; i++) begin
      cyc(2'b10, 1'b0);
      if (bus.sel_changed === 1'b1) begin pulses++; at = cyc_n; end
      n_cmp++;
      if (bus.sel !== 2'(m_pos) || bus.sel_changed !== m_chg) begin
        n_bad++;
        $display("FAIL reset_mid cyc %0d: sel=%0d chg=%b, want sel=%0d chg=%b",
                 cyc_n, bus.sel, bus.sel_changed, m_pos, m_chg);
      end
    end
    n_cmp++;
    if (pulses != 1 || at != r + 8 || bus.sel !== 2'd1) begin
      n_bad++;
      $display("FAIL reset_mid_latency: pulses=%0d at=+%0d sel=%0d, want 1 pulse at +8 sel=1",
               pulses, at - r, bus.sel);
    end
  endtask

  task automatic test_random();
    logic [1:0] k;
    logic r;
    int len;
    cyc(2'b11, 1'b1);
    for (int seg = 0; seg < 400; seg++) begin
      k   = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        r = ($urandom_range(0, 299) == 0);
        cyc(k, r);
        n_cmp++;
        if (bus.sel === 2'd3 || bus.sel !== 2'(m_pos) || bus.LEDR !== 2'(m_pos) ||
            bus.sel_changed !== m_chg) begin
          n_bad++;
          $display("FAIL random cyc %0d: sel=%0d ledr=%0d chg=%b, want sel=%0d chg=%b",
                   cyc_n, bus.sel, bus.LEDR, bus.sel_changed, m_pos, m_chg);
        end
      end
    end
  endtask

  initial begin
    bus.KEY = 2'b11;
    test_reset();
    test_single_press();
    test_three_presses();
    test_bounce();
`ifdef SEL_REVERSE_EN
    test_reverse();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_select_sequencer.md
# mux_select_sequencer

Upstream select generator for the 3-to-1 two-bit channel multiplexer (channels U, V, W). It replaces the static SW[9:8] select with a pushbutton-driven sequencer. Each debounced press of KEY[0] advances the select through U→V→W→U. The resulting 2-bit select drives the multiplexer's S input directly and is mirrored on LEDR for the user.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required before a key level change is accepted (10 ms at 50 MHz); legal range 2..2^20-1.
- CLOCK_50  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- KEY  input  2  raw pushbuttons, active-low, asynchronous to CLOCK_50; KEY[0] = step forward, KEY[1] = step back (see Configuration)
- sel  output  2  multiplexer select: 2'd0 = U, 2'd1 = V, 2'd2 = W; 2'd3 never driven
- sel_changed  output  1  one-cycle pulse in the cycle sel takes a new value
- LEDR  output  2  copy of sel

## Operation
- Per key: 2-flop synchronizer, then inversion to active-high "pressed", then debounce counter, then rising-edge detector producing a one-cycle press strobe.
- Debounce: counter clears whenever the synchronized level equals the debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears. The counter width is $clog2(DEBOUNCE_CYCLES).
- Only press (released→pressed) generates a strobe; release generates nothing.
- Select FSM has three states, SEL_U, SEL_V and SEL_W, with encoding equal to the sel value.
  - Forward strobe: U→V, V→W, W→U.
  - Back strobe: U→W, W→V, V→U.
  - Both strobes in the same cycle: no change, no sel_changed.
- A key held indefinitely yields exactly one step; there is no auto-repeat.
- Glitches shorter than DEBOUNCE_CYCLES samples are ignored, and the counter restarts on every bounce.

## Timing
- Reset values:
  - sel = 2'd0 and LEDR = 2'd0.
  - sel_changed = 0.
  - Synchronizer flops = 1 (released).
  - Debounced levels = released.
  - Counters = 0.
- Latency: with KEY[0] sampled low at edge N and stable thereafter, sel updates and sel_changed = 1 at edge N+DEBOUNCE_CYCLES+3. Of this, 2 cycles are the synchronizer, DEBOUNCE_CYCLES are the debounce count, and 1 cycle is strobe→FSM.
- sel_changed is high for exactly one cycle per step and is coincident with the new sel value.
- Minimum press-to-press interval is 2·DEBOUNCE_CYCLES cycles, because a release must also debounce.
- Reset asserted mid-debounce or mid-press aborts all state to reset values on that edge. A key still held when reset deasserts is treated as a new press, and sel steps at DEBOUNCE_CYCLES+3 edges after the first non-reset edge.
- Reset has priority over any strobe in the same cycle.

## Configuration
- SEL_REVERSE_EN defined: KEY[1] gets its own synchronizer/debounce path and drives the back strobe; simultaneous forward and back strobes cancel.
- SEL_REVERSE_EN undefined:
  - KEY[1] is ignored and no second debounce instance is built.
  - The back strobe is tied to 0.
  - Only forward stepping exists.

## Structure
- Shared package mux_sel_pkg holds:
  - the select encodings SEL_U = 2'd0, SEL_V = 2'd1 and SEL_W = 2'd2;
  - the 2-bit select typedef sel_t;
  - the default debounce constant DEBOUNCE_DEFAULT = 500000.
- Sub-module key_debounce takes CLOCK_50, reset and one raw active-low key. It outputs a debounced level and a press strobe, is parameterized by DEBOUNCE_CYCLES, and is instantiated once per key used.
- The top level contains only the select FSM and output mirroring.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then KEY = 2'b11 for 50 cycles → sel = 0, LEDR = 0, sel_changed never high.
- KEY[0] low from edge N, held 20 cycles, released → sel 0→1 at edge N+7 with a single sel_changed pulse; no further change during hold or release.
- Three clean presses, 20 cycles apart → sel sequence 1, 2, 0; sel never 3; exactly three sel_changed pulses.
- KEY[0] bounces with low pulses of 1, 2 and 3 cycles separated by 1-cycle highs, then stays low → no step until 4 stable samples; exactly one step at 7 cycles after the final falling edge.
- With SEL_REVERSE_EN, from sel = 0:
  - a KEY[1] press gives sel = 2;
  - KEY[0] and KEY[1] falling on the same edge give no change and no sel_changed.
- KEY[0] held, reset pulsed for 1 cycle at mid-debounce (counter = 2) → sel = 0 after reset; with the key still held, sel = 1 at 7 edges after reset deasserts.
